// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: scans a 4x4 active-low matrix keypad, debounces each press,
// decodes it to a hex nibble and shifts digits into a 32-bit entry register
// that feeds an 8-digit seven-segment display driver. Code F acts as backspace.
module hex_keypad_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_in,
  input  logic        clear,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] data_out,
  output logic [3:0]  digit_count
);

  localparam int TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [TW-1:0] SLOT_LAST = TW'(SCAN_DIV - 1);
  // The count reaches DEBOUNCE_SCANS exactly when it is incremented from this value.
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [3:0]    row_meta_reg;
  logic [3:0]    row_sync_reg;
  logic [TW-1:0] timer_reg;
  state_t        state_reg;
  logic [1:0]    col_idx_reg;
  logic [3:0]    col_out_reg;
  logic [1:0]    row_lat_reg;
  logic [CW-1:0] cnt_reg;
  logic          key_valid_reg;
  logic [3:0]    key_code_reg;
  logic [31:0]   data_reg;
  logic [3:0]    count_reg;

  logic          sample;
  logic [3:0]    one_low;
  logic          row_ok;
  logic [1:0]    row_idx;
  logic          commit_next;
  logic [3:0]    code_next;

  assign sample = (timer_reg == SLOT_LAST);

  // Per-row flag: this row is the only one pulled low.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row_pat
      localparam logic [3:0] ROW_PAT = ~(4'b0001 << gi);
      assign one_low[gi] = (row_sync_reg == ROW_PAT);
    end
  endgenerate

  assign row_ok = |one_low;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Encode the single low row into its index (only meaningful when row_ok).
  always_comb begin
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (one_low[i]) row_idx = 2'(i);
    end
  end

  // Commit decision for the current sample; the column is frozen while debouncing.
  always_comb begin
    commit_next = 1'b0;
    code_next   = key_map(row_lat_reg, col_idx_reg);
    if (sample) begin
      if (state_reg == DEBOUNCE && row_ok && row_idx == row_lat_reg && cnt_reg == CNT_LAST) begin
        commit_next = 1'b1;
      end else if (state_reg == SCAN && row_ok && DEBOUNCE_SCANS <= 1) begin
        commit_next = 1'b1;
        code_next   = key_map(row_idx, col_idx_reg);
      end
    end
  end

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_reg <= 4'b1111;
      row_sync_reg <= 4'b1111;
    end else begin
      row_meta_reg <= row_in;
      row_sync_reg <= row_meta_reg;
    end
  end

  // Slot timer: each column is driven for SCAN_DIV cycles, sampled on the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg <= '0;
    end else if (sample) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + TW'(1);
    end
  end

  // Scan / debounce / held state machine; acts only on sample cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= SCAN;
      col_idx_reg <= 2'd0;
      col_out_reg <= 4'b1110;
      row_lat_reg <= 2'd0;
      cnt_reg     <= '0;
    end else if (sample) begin
      case (state_reg)
        SCAN: begin
          if (row_ok) begin
            row_lat_reg <= row_idx;
            if (DEBOUNCE_SCANS <= 1) begin
              state_reg <= HELD;
              cnt_reg   <= '0;
            end else begin
              state_reg <= DEBOUNCE;
              cnt_reg   <= CW'(1);
            end
          end else begin
            col_idx_reg <= col_idx_reg + 2'd1;
            col_out_reg <= {col_out_reg[2:0], col_out_reg[3]};
          end
        end
        DEBOUNCE: begin
          if (row_ok && row_idx == row_lat_reg) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg <= HELD;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end else begin
            state_reg   <= SCAN;
            cnt_reg     <= '0;
            col_idx_reg <= col_idx_reg + 2'd1;
            col_out_reg <= {col_out_reg[2:0], col_out_reg[3]};
          end
        end
        HELD: begin
          // Other keys in the frozen column are ignored: they neither hold nor release.
          if (!row_sync_reg[row_lat_reg]) begin
            cnt_reg <= '0;
          end else if (!row_ok) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg   <= SCAN;
              cnt_reg     <= '0;
              col_idx_reg <= col_idx_reg + 2'd1;
              col_out_reg <= {col_out_reg[2:0], col_out_reg[3]};
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        default: begin
          state_reg <= SCAN;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Entry register: shift in digits, F removes the newest digit, clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'h0;
      data_reg      <= 32'h0;
      count_reg     <= 4'd0;
    end else begin
      key_valid_reg <= commit_next;
      if (commit_next) key_code_reg <= code_next;
      if (clear) begin
        data_reg  <= 32'h0;
        count_reg <= 4'd0;
      end else if (commit_next) begin
        if (code_next == 4'hF) begin
          data_reg  <= {4'h0, data_reg[31:4]};
          count_reg <= (count_reg == 4'd0) ? 4'd0 : count_reg - 4'd1;
        end else begin
          data_reg  <= {data_reg[27:0], code_next};
          count_reg <= (count_reg == 4'd8) ? 4'd8 : count_reg + 4'd1;
        end
      end
    end
  end

  assign col_out     = col_out_reg;
  assign key_valid   = key_valid_reg;
  assign key_code    = key_code_reg;
  assign data_out    = data_reg;
  assign digit_count = count_reg;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a small keypad matrix model.
module tb_hex_keypad_entry;

  localparam int SD = 4;
  localparam int DS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] data_out;
  logic [3:0]  digit_count;

  logic [15:0] keys;
  logic        ovr_en;
  logic [3:0]  ovr_rows;
  logic [3:0]  model_rows;

  int checks   = 0;
  int errors   = 0;
  int kv_count = 0;
  int tcnt     = 0;

  always #5 clk = ~clk;

  hex_keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk),
    .reset(reset),
    .row_in(row_in),
    .clear(clear),
    .col_out(col_out),
    .key_valid(key_valid),
    .key_code(key_code),
    .data_out(data_out),
    .digit_count(digit_count)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    model_rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) model_rows[r] = 1'b0;
  end

  assign row_in = ovr_en ? ovr_rows : model_rows;

  // Count key_valid pulses and track the slot phase.
  always @(posedge clk) begin
    if (key_valid) kv_count <= kv_count + 1;
    if (reset) tcnt <= 0;
    else       tcnt <= (tcnt == SD - 1) ? 0 : tcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge of the first cycle of the next scan slot.
  task automatic slot_start();
    @(negedge clk);
    while (tcnt != 0) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] want);
    int n;
    n = 0;
    do begin
      slot_start();
      n++;
    end while (col_out != want && n < 8);
    check("col_align", col_out, want);
  endtask

  task automatic press(input int r, input int c, input logic [3:0] code,
                       input logic [31:0] exp_data, input logic [3:0] exp_cnt);
    int start;
    int n;
    start = kv_count;
    keys[r*4+c] = 1'b1;
    n = 0;
    while (kv_count == start && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(kv_count != start), 1);
    check("key_code", key_code, code);
    check("data_out", data_out, exp_data);
    check("digit_count", digit_count, exp_cnt);
    repeat (30) @(negedge clk);
    keys = '0;
    repeat (40) @(negedge clk);
    check("single_pulse", kv_count - start, 1);
    $display("press r%0d c%0d code=%h data=%h count=%0d", r, c, key_code, data_out, digit_count);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_data", data_out, 0);
    check("clear_count", digit_count, 0);
    $display("clear data=%h count=%0d", data_out, digit_count);
  endtask

  int          kr [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int          kc [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  logic [31:0] ed [9] = '{32'h1, 32'h12, 32'h123, 32'h1234, 32'h12345, 32'h123456,
                          32'h1234567, 32'h12345678, 32'h23456789};
  logic [3:0]  ec [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8};

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    reset = 1'b1; clear = 1'b0; keys = '0; ovr_en = 1'b0; ovr_rows = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_col", col_out, 4'b1110);
    check("rst_kv", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_data", data_out, 0);
    check("rst_count", digit_count, 0);
    repeat (3) @(negedge clk);
    check("col_slot_end", col_out, 4'b1110);
    @(negedge clk);
    check("col_advance", col_out, 4'b1101);
    $display("reset col=%b data=%h count=%0d", col_out, data_out, digit_count);

    press(0, 1, 4'h2, 32'h2, 4'd1);

    pulse_clear();
    for (int i = 0; i < 9; i++) press(kr[i], kc[i], 4'(i + 1), ed[i], ec[i]);

    pulse_clear();
    press(0, 0, 4'h1, 32'h1, 4'd1);
    press(0, 1, 4'h2, 32'h12, 4'd2);
    press(3, 2, 4'hF, 32'h1, 4'd1);
    press(3, 2, 4'hF, 32'h0, 4'd0);
    press(3, 2, 4'hF, 32'h0, 4'd0);

    // Bounce on row 1: low, high, low, low, high.
    start = kv_count;
    ovr_en = 1'b1; ovr_rows = 4'hF;
    wait_col(4'b1110);
    ovr_rows = 4'b1101;
    slot_start();
    ovr_rows = 4'hF;
    slot_start();
    ovr_rows = 4'b1101;
    slot_start();
    slot_start();
    ovr_rows = 4'hF;
    slot_start();
    check("bounce_col_a", col_out, 4'b1011);
    slot_start();
    check("bounce_col_b", col_out, 4'b0111);
    check("bounce_no_kv", kv_count - start, 0);
    check("bounce_data", data_out, 0);
    $display("bounce col=%b pulses=%0d data=%h", col_out, kv_count - start, data_out);

    // Two rows low in the same column.
    ovr_en = 1'b0;
    start = kv_count;
    keys[0] = 1'b1; keys[4] = 1'b1;
    repeat (60) @(negedge clk);
    check("two_rows_no_kv", kv_count - start, 0);
    check("two_rows_data", data_out, 0);
    keys = '0;
    repeat (10) @(negedge clk);
    $display("two_rows pulses=%0d data=%h", kv_count - start, data_out);

    press(1, 1, 4'h5, 32'h5, 4'd1);

    // Clear coinciding with the commit of '7'.
    ovr_en = 1'b1; ovr_rows = 4'hF;
    wait_col(4'b1110);
    ovr_rows = 4'b1011;
    slot_start();
    slot_start();
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_commit_kv", key_valid, 1);
    check("clr_commit_code", key_code, 4'h7);
    check("clr_commit_data", data_out, 0);
    check("clr_commit_count", digit_count, 0);
    $display("clear_on_commit kv=%b code=%h data=%h count=%0d", key_valid, key_code, data_out, digit_count);
    ovr_rows = 4'hF;
    repeat (40) @(negedge clk);

    ovr_en = 1'b0;
    press(2, 2, 4'h9, 32'h9, 4'd1);

    // Reset while debouncing '8'.
    ovr_en = 1'b1; ovr_rows = 4'hF;
    wait_col(4'b1101);
    ovr_rows = 4'b1011;
    slot_start();
    check("debounce_frozen", col_out, 4'b1101);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_col", col_out, 4'b1110);
    check("mid_rst_kv", key_valid, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_count", digit_count, 0);
    $display("mid_reset col=%b code=%h data=%h count=%0d", col_out, key_code, data_out, digit_count);
    reset = 1'b0;
    ovr_rows = 4'hF;
    start = kv_count;
    repeat (40) @(negedge clk);
    check("post_rst_no_kv", kv_count - start, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_keypad_entry.md
Name: hex_keypad_entry

Overview:
- Input-side counterpart of the 8-digit seven-segment display path. It scans a 4x4 active-low matrix keypad, debounces presses and decodes each press to a hex nibble.
- Decoded nibbles are shifted into a 32-bit entry register that feeds the display driver's 32-bit data input directly (digit 0 = bits [3:0]).
- Single clock domain; one decoded key per physical press.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven per scan slot; rows are sampled on the last cycle of the slot. Minimum 2.
- DEBOUNCE_SCANS, 8: consecutive matching samples required to accept a press or a release. Minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- row_in  input  4  keypad rows, active-low, pulled up, asynchronous to clk
- clear  input  1  synchronous pulse; zeroes the entry
- col_out  output  4  keypad column drive, active-low, exactly one bit low at all times
- key_valid  output  1  one-cycle pulse when a debounced key is accepted
- key_code  output  4  code of the last accepted key, held until the next accept
- data_out  output  32  entry register; most recent digit in [3:0]
- digit_count  output  4  number of entered digits, 0..8

Behaviour:
- row_in passes through a 2-flop synchronizer (reset value 4'b1111); all decisions use the synchronized value.
- Key map (row r, column c -> code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- Code F is backspace, not a digit.
- Slot timer counts 0..SCAN_DIV-1 and wraps; a sample occurs when the timer equals SCAN_DIV-1.
- A valid sample has exactly one row bit low. Zero or several low bits count as "none".
- FSM states:
  - SCAN: col_out rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110 after each sample. A valid sample latches (row, col), resets the debounce count to 1 and enters DEBOUNCE. The column freezes.
  - DEBOUNCE: a sample matching the latched row increments the count. Reaching DEBOUNCE_SCANS enters HELD and commits the key. A mismatch or "none" returns to SCAN and advances to the next column.
  - HELD: the column stays frozen. A sample with the latched row still low resets the release count. A "none" sample increments it; reaching DEBOUNCE_SCANS returns to SCAN and advances the column. Other keys pressed while HELD are ignored.
- Commit (one edge, on the cycle after the final debounce sample):
  - key_valid=1; key_code=code.
  - For digit codes: data_out <= {data_out[27:0], code}; digit_count saturates at 8, and the old [31:28] is discarded when full.
  - For code F (backspace): data_out <= {4'h0, data_out[31:4]}; digit_count decrements, saturating at 0.
- Accepted-press latency: sample-to-key_valid is 1 cycle. Physical press to commit is at most 2 + SCAN_DIV*(4 + DEBOUNCE_SCANS) cycles.
- clear: data_out=0 and digit_count=0 on the next edge. clear has priority over a simultaneous commit. In that case key_valid still pulses and key_code still updates, but the entry stays zero. The FSM is unaffected.
- Reset (any cycle, including mid-debounce):
  - col_out=4'b1110, key_valid=0, key_code=0, data_out=0, digit_count=0.
  - State SCAN; slot timer and debounce counts 0; synchronizer 4'b1111.
- A held key never auto-repeats.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
- Reset asserted for 2 cycles, then released -> col_out=1110, data_out=0, digit_count=0, key_valid=0. col_out advances to 1101 at the first sample after the slot timer reaches 3.
- Press r0/c1 ('2') stable until accepted, then release -> exactly one key_valid pulse with key_code=2, data_out=0x00000002, digit_count=1. No further pulse while held or after release.
- Enter 1,2,3,4,5,6,7,8,9 -> after 8 digits data_out=0x12345678 and digit_count=8. After '9': data_out=0x23456789, digit_count=8.
- From 0x00000012 (count 2), press '#' -> key_code=F, data_out=0x00000001, digit_count=1. Two more '#' presses -> data_out=0, count=0.
- Bounce: r1/c0 ('4') low for 1 sample, high, low for 2 samples, then high -> no key_valid, FSM back in SCAN, data_out unchanged.
- Two rows low on the same column -> no commit. Assert clear on the commit cycle of '7' -> key_valid=1, key_code=7, data_out=0, digit_count=0. Reset mid-DEBOUNCE -> all outputs at reset values next cycle.
